// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and the divide-by-zero quotient value.
package seq_divider_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned CNT_W     = 6;

  // Quotient returned for a zero divisor (all ones, as RISC-V DIV/DIVU)
  localparam logic [DEF_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the sequential divider; the requester drives the
// master side, the divider implements the slave side.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );

endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference when it does not borrow.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  always_comb begin
    shifted        = {rem_i, bit_i};
    {borrow, diff} = {1'b0, shifted} - {2'b00, dvsr_i};
    q_o            = ~borrow;
    // A kept difference is always below the divisor, so it fits WIDTH bits
    rem_o          = WIDTH'(borrow ? shifted : diff);
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential DIV/DIVU: operands latched on start, WIDTH restoring iterations,
// sign fix-up folded into the last iteration; results held until next start.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_final;
  logic             a_neg, b_neg;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (quo_q[WIDTH-1]),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      dvd_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      dvd_q       <= dvd_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    dvd_d       = dvd_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    a_neg   = bus.is_signed & bus.dividend[WIDTH-1];
    b_neg   = bus.is_signed & bus.divisor[WIDTH-1];
    q_final = {quo_q[WIDTH-2:0], step_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // quo_q starts as the dividend magnitude and fills with quotient bits
          quo_d   = a_neg ? -bus.dividend : bus.dividend;
          dvsr_d  = b_neg ? -bus.divisor  : bus.divisor;
          rem_d   = '0;
          dvd_d   = bus.dividend;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (dvsr_q == '0) begin
          quotient_d  = WIDTH'(signed'(DIV0_QUOTIENT));
          remainder_d = dvd_q;
          div_zero_d  = 1'b1;
          state_d     = DONE;
        end else begin
          rem_d = step_rem;
          quo_d = q_final;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quotient_d  = negq_q ? -q_final  : q_final;
            remainder_d = negr_q ? -step_rem : step_rem;
            div_zero_d  = 1'b0;
            state_d     = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule
